// File: rtl/fir_pkg.sv
// Shared types for the fir datapath: cache-line packing of the 8-bit filtered
// sample stream for the CCI-P write path.
package fir_pkg;

   localparam int FIR_LINE_BYTES = 64;

   typedef logic [511:0] t_fir_line;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DRAIN,
      DONE
   } t_packer_state;

   typedef struct packed {
      t_fir_line  data;
      logic [6:0] bytes;
      logic       last;
   } t_fir_line_entry;

endpackage

// File: rtl/fir_line_fifo.sv
// Synchronous show-ahead FIFO of packed lines. A push into a full FIFO is
// accepted when a pop happens in the same cycle, since the pop frees the slot.
module fir_line_fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  t_fir_line_entry push_data,
   input  logic            pop,
   output t_fir_line_entry head,
   output logic            full,
   output logic            empty
);

   localparam int AW = $clog2(DEPTH);

   t_fir_line_entry mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic            do_pop;
   logic            do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // entries are live, and the top masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/fir_line_packer.sv
// Packs the 8-bit fir sample stream into 512-bit lines, buffers completed
// lines against write backpressure and flushes a partial line at end of stream.
module fir_line_packer
   import fir_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   data_in,
   input  logic         valid_in,
   input  logic         flush,
   output logic [511:0] line_out,
   output logic [6:0]   line_bytes,
   output logic         line_last,
   output logic         line_valid,
   input  logic         line_ready,
   output logic         done,
   output logic         overflow,
   output logic [31:0]  line_count
);

   t_packer_state   state;
   t_packer_state   state_next;
   logic [5:0]      fill;
   t_fir_line       line_q;
   t_fir_line       line_with_byte;
   t_fir_line_entry push_entry;
   t_fir_line_entry head;
   logic            push;
   logic            pop;
   logic            space;
   logic            full;
   logic            empty;
   logic            accept_byte;
   logic            line_done;

   assign pop         = line_valid && line_ready;
   assign space       = !full || pop;
   assign accept_byte = valid_in && (state == RUN);
   assign line_done   = accept_byte && (fill == 6'(FIR_LINE_BYTES - 1));

   // Current line with this cycle's byte merged in, so the 64th byte can be
   // pushed straight into the FIFO without an extra register stage.
   always_comb begin
      line_with_byte = line_q;
      line_with_byte[8*fill +: 8] = data_in;
   end

   // NOTE: every output of this block gets a default first so no path through
   // the case statement leaves a value held, which would infer a latch.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      push_entry = '{data: line_with_byte, bytes: 7'(FIR_LINE_BYTES), last: flush};
      case (state)
         RUN: begin
            push = line_done && space;
            if (flush) state_next = FLUSH;
         end
         FLUSH: begin
            if (fill == '0) begin
               state_next = DRAIN;
            end else if (space) begin
               push       = 1'b1;
               push_entry = '{data: line_q, bytes: {1'b0, fill}, last: 1'b1};
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (empty) state_next = DONE;
         end
         DONE: begin
            state_next = RUN;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         fill       <= '0;
         line_q     <= '0;
         overflow   <= 1'b0;
         line_count <= '0;
      end else begin
         state <= state_next;
         if (pop) line_count <= line_count + 32'd1;
         if ((line_done && !space) || (valid_in && state != RUN)) overflow <= 1'b1;
         // Cleared line storage keeps the unused bytes of a partial line zero.
         if (line_done || state == DONE) begin
            fill   <= '0;
            line_q <= '0;
         end else if (accept_byte) begin
            fill   <= fill + 6'd1;
            line_q <= line_with_byte;
         end
      end
   end

   fir_line_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign done       = (state == DONE);
   assign line_valid = !empty;
   assign line_out   = empty ? '0 : head.data;
   assign line_bytes = empty ? '0 : head.bytes;
   assign line_last  = empty ? 1'b0 : head.last;

endmodule
